// File: rtl/iomem_pkg.sv
// Shared types for the I/O hub: region select, I/O register offsets, status/control bit positions.
package iomem_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_VRAM = 2'd1,
    REG_IO   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  localparam logic [1:0] IO_KBD_DATA = 2'd0;
  localparam logic [1:0] IO_KBD_STAT = 2'd1;
  localparam logic [1:0] IO_KBD_CTRL = 2'd2;
  localparam logic [1:0] IO_TICK     = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_FAULT = 3;

  localparam int CTRL_FLUSH     = 0;
  localparam int CTRL_CLR_OVF   = 1;
  localparam int CTRL_CLR_FAULT = 2;

  // Word offset relative to a region base is a hit when below the region size.
  function automatic logic in_region(input logic [29:0] off, input logic [30:0] size);
    return ({1'b0, off} < size);
  endfunction

endpackage

// File: rtl/iomem_hub_if.sv
// Core data-port bus between the CPU (master) and the I/O hub (slave).
interface iomem_hub_if;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] data_input;
  logic [31:0] data_output;
  logic        data_valid;

  modport master (
    output write_enable, read_enable, address, data_input,
    input  data_output, data_valid
  );

  modport slave (
    input  write_enable, read_enable, address, data_input,
    output data_output, data_valid
  );
endinterface

// File: rtl/iomem_hub_kbd_fifo.sv
// Keyboard scan-byte FIFO with sticky overflow flag; flush has priority over push and pop.
// With IOMEM_KBD_IRQ_EN defined, also provides a registered interrupt (non-empty or overflow).
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
`ifdef IOMEM_KBD_IRQ_EN
  output logic                   irq,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   clr_ovf,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             do_push_s, do_pop_s;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign dout     = mem_q[rd_q];

  // Next-state: a full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty & ~flush;
    do_push_s = push & ~flush & (~full | do_pop_s);
    ovf_d     = (ovf_q & ~clr_ovf) | (push & ~flush & full & ~do_pop_s);
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = do_push_s ? wr_q + PW'(1) : wr_q;
      rd_d  = do_pop_s ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
    end
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q] <= din;
  end

`ifdef IOMEM_KBD_IRQ_EN
  // Interrupt follows next state so it drops the cycle after the emptying pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (cnt_d != '0) | ovf_d;
  end
`endif

endmodule

// File: rtl/iomem_hub.sv
// Memory-mapped I/O hub: decodes RAM/VRAM/IO regions, registers read select, owns tick/status/control.
// Optional keyboard interrupt output enabled by defining IOMEM_KBD_IRQ_EN.
module iomem_hub
  import iomem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          RAM_AW     = 12,
  parameter logic [31:0] VRAM_BASE  = 32'h0001_0000,
  parameter int          VRAM_WORDS = 10,
  parameter logic [31:0] IO_BASE    = 32'h0002_0000,
  parameter int          KBD_DEPTH  = 8,
  localparam int         VAW        = (VRAM_WORDS > 1) ? $clog2(VRAM_WORDS) : 1
) (
`ifdef IOMEM_KBD_IRQ_EN
  output logic              kbd_irq,
`endif
  input  logic              clk,
  input  logic              rst,
  iomem_hub_if.slave        bus,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_byte,
  output logic              ram_we,
  output logic              vram_we,
  output logic [RAM_AW-1:0] ram_address,
  output logic [VAW-1:0]    vram_address,
  output logic [31:0]       ram_wdata,
  output logic [31:0]       vram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [31:0]       vram_rdata
);

  localparam int KPW = $clog2(KBD_DEPTH);

  logic [29:0] word_s, ram_off_s, vram_off_s, io_off_s;
  logic [1:0]  io_reg_s;
  region_e     region_s, sel_q, sel_d;
  logic        rd_acc_s, wr_acc_s, io_wr_s, io_rd_s;
  logic        pop_s, flush_s, clr_ovf_s, clr_fault_s, tick_ld_s;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic [31:0] tick_q, tick_d, tick_next_s, io_q, io_d;
  logic [7:0]  kbd_dout_s, cnt8_s;
  logic [KPW:0] kbd_cnt_s;
  logic        kbd_full_s, kbd_empty_s, kbd_ovf_s;
  logic        unused_s;

  assign word_s     = bus.address[31:2];
  assign ram_off_s  = word_s - RAM_BASE[31:2];
  assign vram_off_s = word_s - VRAM_BASE[31:2];
  assign io_off_s   = word_s - IO_BASE[31:2];
  assign io_reg_s   = io_off_s[1:0];
  assign unused_s   = &{1'b0, bus.address[1:0]};

  // Region decode; addresses below a base wrap to huge offsets and miss.
  always_comb begin
    region_s = REG_NONE;
    if (in_region(ram_off_s, 31'(2**RAM_AW)))        region_s = REG_RAM;
    else if (in_region(vram_off_s, 31'(VRAM_WORDS))) region_s = REG_VRAM;
    else if (in_region(io_off_s, 31'd4))             region_s = REG_IO;
    else                                             region_s = REG_NONE;
  end

  // A simultaneous write wins; the read is dropped.
  assign wr_acc_s    = bus.write_enable;
  assign rd_acc_s    = bus.read_enable & ~bus.write_enable;
  assign io_wr_s     = wr_acc_s & (region_s == REG_IO);
  assign io_rd_s     = rd_acc_s & (region_s == REG_IO);
  assign flush_s     = io_wr_s & (io_reg_s == IO_KBD_CTRL) & bus.data_input[CTRL_FLUSH];
  assign clr_ovf_s   = io_wr_s & (io_reg_s == IO_KBD_CTRL) & bus.data_input[CTRL_CLR_OVF];
  assign clr_fault_s = io_wr_s & (io_reg_s == IO_KBD_CTRL) & bus.data_input[CTRL_CLR_FAULT];
  assign tick_ld_s   = io_wr_s & (io_reg_s == IO_TICK);
  assign pop_s       = io_rd_s & (io_reg_s == IO_KBD_DATA);

  // Strobes are held off while reset is asserted so an interrupted write never lands.
  assign ram_we       = rst & wr_acc_s & (region_s == REG_RAM);
  assign vram_we      = rst & wr_acc_s & (region_s == REG_VRAM);
  assign ram_address  = ram_off_s[RAM_AW-1:0];
  assign vram_address = vram_off_s[VAW-1:0];
  assign ram_wdata    = bus.data_input;
  assign vram_wdata   = bus.data_input;

  assign cnt8_s      = 8'(kbd_cnt_s);
  assign tick_next_s = tick_q + 32'd1;

  kbd_fifo #(.DEPTH(KBD_DEPTH), .WIDTH(8)) u_kbd_fifo (
`ifdef IOMEM_KBD_IRQ_EN
    .irq      (kbd_irq),
`endif
    .clk      (clk),
    .rst      (rst),
    .push     (kbd_valid),
    .pop      (pop_s),
    .flush    (flush_s),
    .clr_ovf  (clr_ovf_s),
    .din      (kbd_byte),
    .dout     (kbd_dout_s),
    .count    (kbd_cnt_s),
    .full     (kbd_full_s),
    .empty    (kbd_empty_s),
    .overflow (kbd_ovf_s)
  );

  // Next-state for read pipeline, tick and fault; TICK reads report the value held in the data cycle.
  always_comb begin
    valid_d = 1'b0;
    sel_d   = REG_NONE;
    io_d    = 32'd0;
    tick_d  = tick_ld_s ? bus.data_input : tick_next_s;
    fault_d = (fault_q & ~clr_fault_s) | ((rd_acc_s | wr_acc_s) & (region_s == REG_NONE));
    if (rd_acc_s) begin
      valid_d = 1'b1;
      sel_d   = region_s;
      case (io_reg_s)
        IO_KBD_DATA: io_d = kbd_empty_s ? 32'd0 : {24'd0, kbd_dout_s};
        IO_KBD_STAT: begin
          io_d[15:8]       = cnt8_s;
          io_d[STAT_FAULT] = fault_q;
          io_d[STAT_OVF]   = kbd_ovf_s;
          io_d[STAT_FULL]  = kbd_full_s;
          io_d[STAT_EMPTY] = kbd_empty_s;
        end
        IO_TICK:     io_d = tick_next_s;
        default:     io_d = 32'd0;
      endcase
    end else begin
      valid_d = 1'b0;
      sel_d   = REG_NONE;
    end
  end

  // Hub state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sel_q   <= REG_NONE;
      io_q    <= 32'd0;
      tick_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      io_q    <= io_d;
      tick_q  <= tick_d;
      fault_q <= fault_d;
    end
  end

  // Read data mux in the data_valid cycle; memories supply their synchronous read data directly.
  always_comb begin
    bus.data_output = 32'd0;
    if (valid_q) begin
      case (sel_q)
        REG_RAM:  bus.data_output = ram_rdata;
        REG_VRAM: bus.data_output = vram_rdata;
        REG_IO:   bus.data_output = io_q;
        default:  bus.data_output = 32'd0;
      endcase
    end else begin
      bus.data_output = 32'd0;
    end
  end

  assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_iomem_hub.sv
// Directed bench for iomem_hub with a queue/array reference model checked every cycle.
module tb_iomem_hub;

  localparam logic [31:0] IO   = 32'h0002_0000;
  localparam logic [31:0] VRAM = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        kbd_valid;
  logic [7:0]  kbd_byte;
  logic        ram_we, vram_we;
  logic [11:0] ram_address;
  logic [3:0]  vram_address;
  logic [31:0] ram_wdata, vram_wdata, ram_rdata, vram_rdata;
`ifdef IOMEM_KBD_IRQ_EN
  logic        kbd_irq;
`endif

  iomem_hub_if bus ();

  iomem_hub dut (
`ifdef IOMEM_KBD_IRQ_EN
    .kbd_irq      (kbd_irq),
`endif
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .kbd_valid    (kbd_valid),
    .kbd_byte     (kbd_byte),
    .ram_we       (ram_we),
    .vram_we      (vram_we),
    .ram_address  (ram_address),
    .vram_address (vram_address),
    .ram_wdata    (ram_wdata),
    .vram_wdata   (vram_wdata),
    .ram_rdata    (ram_rdata),
    .vram_rdata   (vram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories driven by the DUT strobes.
  bit [31:0] ram_mem [4096];
  bit [31:0] vram_mem [16];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_wdata;
    if (vram_we) vram_mem[vram_address] <= vram_wdata;
    ram_rdata  <= ram_mem[ram_address];
    vram_rdata <= vram_mem[vram_address];
  end

  // Reference model state.
  bit [31:0]  exp_ram [4096];
  bit [31:0]  exp_vram [10];
  logic [7:0] m_q [$];
  bit         m_ovf, m_fault;
  logic [31:0] m_tv;
  int         m_tl, m_cyc;
  bit         mdl_valid, mdl_irq, mdl_ram_we, mdl_vram_we;
  logic [31:0] mdl_data, mdl_ram_addr;
  bit         chk_en;
  int         n_chk, n_pass;

  always @(posedge clk) if (rst) m_cyc <= m_cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int region_of(input logic [31:0] a, output int off);
    longint w;
    w = longint'(a[31:2]);
    off = 0;
    if (w < 4096) begin off = int'(w); return 0; end
    if (w >= 'h4000 && w < 'h4000 + 10) begin off = int'(w - 'h4000); return 1; end
    if (w >= 'h8000 && w < 'h8000 + 4) begin off = int'(w - 'h8000); return 2; end
    return 3;
  endfunction

  function automatic logic [31:0] stat_val();
    int n;
    n = m_q.size();
    return {16'd0, 8'(n), 4'd0, m_fault, m_ovf, 1'(n == 8), 1'(n == 0)};
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("data_valid", {31'd0, bus.data_valid}, {31'd0, mdl_valid});
      if (mdl_valid) check("data_output", bus.data_output, mdl_data);
      check("ram_we", {31'd0, ram_we}, {31'd0, mdl_ram_we});
      check("vram_we", {31'd0, vram_we}, {31'd0, mdl_vram_we});
      if (mdl_ram_we) check("ram_address", {20'd0, ram_address}, mdl_ram_addr);
`ifdef IOMEM_KBD_IRQ_EN
      check("kbd_irq", {31'd0, kbd_irq}, {31'd0, mdl_irq});
`endif
    end
  end

  // One bus cycle plus optional keyboard pulse; the model is updated by the same rules.
  task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd,
                    input bit kv, input logic [7:0] kb, input int lit_ram = -1);
    int rg, off;
    bit pend, flush, tload;
    logic [31:0] pd;
    rg = region_of(a, off);
    pend = 1'b0; flush = 1'b0; tload = 1'b0; pd = 32'd0;
    bus.write_enable = we; bus.read_enable = re; bus.address = a; bus.data_input = wd;
    kbd_valid = kv; kbd_byte = kb;
    mdl_ram_we = we && rg == 0;
    mdl_vram_we = we && rg == 1;
    mdl_ram_addr = off;
    if (we) begin
      case (rg)
        0: exp_ram[off] = wd;
        1: exp_vram[off] = wd;
        2: begin
          if (off == 2) begin
            flush = wd[0];
            if (wd[0]) m_q.delete();
            if (wd[1]) m_ovf = 1'b0;
            if (wd[2]) m_fault = 1'b0;
          end
          if (off == 3) tload = 1'b1;
        end
        default: m_fault = 1'b1;
      endcase
    end else if (re) begin
      pend = 1'b1;
      case (rg)
        0: pd = exp_ram[off];
        1: pd = exp_vram[off];
        2: begin
          if (off == 0 && m_q.size() != 0) pd = {24'd0, m_q.pop_front()};
          else if (off == 1) pd = stat_val();
          else if (off == 3) pd = m_tv + 32'(m_cyc + 1 - m_tl);
        end
        default: m_fault = 1'b1;
      endcase
    end
    if (kv && !flush) begin
      if (m_q.size() < 8) m_q.push_back(kb);
      else m_ovf = 1'b1;
    end
    if (lit_ram >= 0) begin
      #2;
      check("t1_ram_we", {31'd0, ram_we}, 32'd1);
      check("t1_ram_address", {20'd0, ram_address}, lit_ram);
    end
    @(posedge clk); #1;
    if (tload) begin m_tv = wd; m_tl = m_cyc; end
    mdl_valid = pend;
    mdl_data = pd;
    mdl_irq = (m_q.size() != 0) || m_ovf;
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    op(1'b0, 1'b1, a, 32'd0, 1'b0, 8'd0);
    check({name, "_valid"}, {31'd0, bus.data_valid}, 32'd1);
    check(name, bus.data_output, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, a, d, 1'b0, 8'd0);
  endtask

  task automatic push(input logic [7:0] b);
    op(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, b);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; chk_en = 1'b0; m_cyc = 0; m_tv = 32'd0; m_tl = 0;
    bus.write_enable = 1'b0; bus.read_enable = 1'b0; bus.address = 32'd0; bus.data_input = 32'd0;
    kbd_valid = 1'b0; kbd_byte = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_data_output", bus.data_output, 32'd0);
    rst = 1'b1; chk_en = 1'b1;
    rd_lit("rst_stat", IO + 32'd4, 32'h0000_0001);

    // RAM and VRAM write/read, including last RAM word and write+read collision.
    op(1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, 8'd0, 4);
    rd_lit("t1_ram_read", 32'h0000_0010, 32'h1234_5678);
    wr(32'h0000_3FFC, 32'hA5A5_0001);
    wr(VRAM + 32'd12, 32'hCAFE_BABE);
    wr(VRAM + 32'd36, 32'h0BAD_F00D);
    op(1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 8'd0);
    op(1'b0, 1'b1, 32'h0000_0020, 32'd0, 1'b0, 8'd0);
    op(1'b0, 1'b1, 32'h0000_3FFC, 32'd0, 1'b0, 8'd0);
    op(1'b0, 1'b1, VRAM + 32'd12, 32'd0, 1'b0, 8'd0);
    op(1'b0, 1'b1, VRAM + 32'd36, 32'd0, 1'b0, 8'd0);

    // Two scan bytes out in order, then empty.
    push(8'h1C);
    push(8'h32);
    rd_lit("t2_pop0", IO, 32'h0000_001C);
    rd_lit("t2_pop1", IO, 32'h0000_0032);
    rd_lit("t2_pop_empty", IO, 32'h0000_0000);
    rd_lit("t2_stat", IO + 32'd4, 32'h0000_0001);
    op(1'b0, 1'b1, IO, 32'd0, 1'b1, 8'h77);
    op(1'b0, 1'b1, IO, 32'd0, 1'b0, 8'd0);

    // Overflow then clear.
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
    rd_lit("t3_stat_ovf", IO + 32'd4, 32'h0000_0806);
    wr(IO + 32'd8, 32'h0000_0002);
    rd_lit("t3_stat_clr", IO + 32'd4, 32'h0000_0802);

    // Push and pop together while full, then drain.
    op(1'b0, 1'b1, IO, 32'd0, 1'b1, 8'hEE);
    check("t4_popped", bus.data_output, 32'h0000_00A0);
    rd_lit("t4_stat", IO + 32'd4, 32'h0000_0802);
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, IO, 32'd0, 1'b0, 8'd0);
    op(1'b0, 1'b1, IO + 32'd4, 32'd0, 1'b0, 8'd0);

    // Flush wins over a same-cycle push.
    push(8'h11);
    push(8'h22);
    op(1'b1, 1'b0, IO + 32'd8, 32'h0000_0001, 1'b1, 8'h33);
    rd_lit("flush_stat", IO + 32'd4, 32'h0000_0001);

    // Unmapped accesses and fault clear.
    rd_lit("t5_unmapped", VRAM + 32'd40, 32'h0000_0000);
    rd_lit("t5_fault", IO + 32'd4, 32'h0000_0009);
    wr(IO + 32'd8, 32'h0000_0004);
    wr(32'h0000_4000, 32'h5555_5555);
    op(1'b0, 1'b1, IO + 32'd4, 32'd0, 1'b0, 8'd0);
    wr(IO + 32'd8, 32'h0000_0004);
    op(1'b0, 1'b1, IO + 32'd8, 32'd0, 1'b0, 8'd0);

    // Tick load and wrap.
    wr(IO + 32'd12, 32'hFFFF_FFFE);
    idle();
    rd_lit("t5_tick_wrap", IO + 32'd12, 32'h0000_0000);
    op(1'b0, 1'b1, IO + 32'd12, 32'd0, 1'b0, 8'd0);

    // Reset asserted in the middle of a KBD_DATA read.
    push(8'h5A);
    chk_en = 1'b0;
    bus.read_enable = 1'b1; bus.address = IO;
    mdl_ram_we = 1'b0; mdl_vram_we = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("t6_rst_data", bus.data_output, 32'd0);
    bus.read_enable = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_fault = 1'b0; m_tv = 32'd0; m_tl = m_cyc;
    mdl_valid = 1'b0; mdl_irq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; chk_en = 1'b1;
    rd_lit("t6_stat", IO + 32'd4, 32'h0000_0001);
    push(8'h42);
    op(1'b0, 1'b1, IO, 32'd0, 1'b0, 8'd0);
    op(1'b0, 1'b1, IO + 32'd12, 32'd0, 1'b0, 8'd0);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
